// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the i2c_arbiter block.
// States, default sizing and field width.
package i2c_arb_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int TIMEOUT_DEF = 1_000_000;
  localparam int FW          = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACCEPT,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or after rr_ptr, wrapping modulo NUM_REQ.
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PW:0]          sum;
  logic                 found;

  // rot[k] is req[(rr_ptr + k) mod NUM_REQ]
  always_comb begin
    dbl   = {req, req} >> rr_ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (PW+1)'(k);
      end
    end
    if (sum >= (PW+1)'(NUM_REQ)) begin
      sum = sum - (PW+1)'(NUM_REQ);
    end
    idx   = sum[PW-1:0];
    valid = found;
    gnt   = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller among
// NUM_REQ requesters, with a per-transaction timeout.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  clk_ref,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [FW*NUM_REQ-1:0] req_dev_addr,
  input  logic [FW*NUM_REQ-1:0] req_reg_addr,
  input  logic [FW*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic                  ctrl_start,
  output logic [FW-1:0]         ctrl_dev_addr,
  output logic [FW-1:0]         ctrl_reg_addr,
  output logic [FW-1:0]         ctrl_data,
  input  logic                  ctrl_ready,
  output logic                  busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               start_q, start_d;
  logic [FW-1:0]      dev_q, dev_d;
  logic [FW-1:0]      reg_q, reg_d;
  logic [FW-1:0]      data_q, data_d;
  logic [PW-1:0]      win_q, win_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_valid;
  logic [PW-1:0]      rr_next;
  logic               completing;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign rr_next = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = '0;
    start_d    = 1'b0;
    dev_d      = dev_q;
    reg_d      = reg_q;
    data_d     = data_q;
    win_d      = win_q;
    rr_d       = rr_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    completing = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (pick_valid) begin
          state_d = LAUNCH;
          grant_d = pick_gnt;
          win_d   = pick_idx;
          cnt_d   = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
              dev_d  = req_dev_addr[i*FW +: FW];
              reg_d  = req_reg_addr[i*FW +: FW];
              data_d = req_data[i*FW +: FW];
            end
          end
        end
      end
      LAUNCH: begin
        if (ctrl_ready) begin
          start_d = 1'b1;
          state_d = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        start_d = ctrl_ready;
        if (!ctrl_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ctrl_ready) begin
          completing = 1'b1;
          done_d     = grant_q;
          grant_d    = '0;
          rr_d       = rr_next;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A completion seen on the last cycle still wins over abort
    if (state_q != IDLE && !completing && cnt_q == CNT_LAST) begin
      err_d   = grant_q;
      done_d  = '0;
      start_d = 1'b0;
      grant_d = '0;
      rr_d    = rr_next;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      win_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign err           = err_q;
  assign ctrl_start    = start_q;
  assign ctrl_dev_addr = dev_q;
  assign ctrl_reg_addr = reg_q;
  assign ctrl_data     = data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing one i2c_controller.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: maximum clk_ref cycles from launch to completion before abort.
REQ-003 clk_ref  input  1  single clock, 50 MHz; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester transaction request, level.
REQ-006 req_dev_addr  input  8*NUM_REQ  per-requester I2C device address, slice i = bits [8i+7:8i].
REQ-007 req_reg_addr  input  8*NUM_REQ  per-requester register address, same packing.
REQ-008 req_data  input  8*NUM_REQ  per-requester write data, same packing.
REQ-009 grant  output  NUM_REQ  one-hot; bit i high while requester i owns the controller.
REQ-010 done  output  NUM_REQ  one-cycle pulse; transaction for requester i completed.
REQ-011 err  output  NUM_REQ  one-cycle pulse; transaction for requester i aborted on timeout.
REQ-012 ctrl_start  output  1  start to i2c_controller.
REQ-013 ctrl_dev_addr, ctrl_reg_addr, ctrl_data  output  8 each  registered fields to i2c_controller.
REQ-014 ctrl_ready  input  1  i2c_controller ready_out; high = idle.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT_ACCEPT, WAIT_DONE.
REQ-017 IDLE: if any req bit high, select winner by round-robin starting at pointer rr_ptr; next cycle grant one-hot to winner, fields captured into ctrl_* registers, state LAUNCH.
REQ-018 Round-robin: search order rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ; first set bit wins.
REQ-019 LAUNCH: when ctrl_ready=1, drive ctrl_start=1 and go to WAIT_ACCEPT; otherwise hold in LAUNCH with ctrl_start=0.
REQ-020 WAIT_ACCEPT: hold ctrl_start=1 until ctrl_ready=0 is sampled; then ctrl_start=0 on the following cycle, state WAIT_DONE.
REQ-021 WAIT_DONE: on ctrl_ready=1, pulse done[winner] for exactly one cycle, clear grant in the same cycle, set rr_ptr = (winner+1) mod NUM_REQ, return to IDLE.
REQ-022 Minimum gap: at least one IDLE cycle between consecutive grants.
REQ-023 ctrl_* field registers change only on IDLE->LAUNCH; stable for the whole transaction.
REQ-024 Requester deasserting req after grant does not abort; transaction completes and done still pulses.
REQ-025 Requester holding req high through done is re-queued at lowest priority due to pointer advance.
REQ-026 Timeout counter clears on IDLE->LAUNCH, increments each cycle in LAUNCH/WAIT_ACCEPT/WAIT_DONE; at TIMEOUT_CYCLES-1: pulse err[winner], ctrl_start=0, grant cleared, rr_ptr advanced as REQ-021, state IDLE; done not asserted.
REQ-027 Counter width = clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
REQ-028 done and err are never asserted in the same cycle; at most one bit of grant/done/err high at any time.
REQ-029 Requests arriving during a transaction are held off (no queuing inside the block); they are served when the request line is still high in IDLE.

Reset
REQ-030 reset=1 at a clock edge: state IDLE, grant=0, done=0, err=0, ctrl_start=0, ctrl_* fields=0, rr_ptr=0, timeout counter=0, busy=0.
REQ-031 Reset mid-transaction takes effect the next edge regardless of state; no done/err pulse issued for the aborted transfer.

Structure
REQ-032 Package i2c_arb_pkg holds state encodings, default NUM_REQ, TIMEOUT_CYCLES, and field width 8.
REQ-033 Sub-module i2c_rr_pick: combinational round-robin picker (req, rr_ptr -> one-hot winner, valid).

Verification
REQ-034 Single req[0] with dev=0x72 reg=0x41 data=0x10; model ready low 20 cycles -> ctrl_* = 72/41/10, ctrl_start high until ready low, done[0] one pulse, grant[0] cleared.
REQ-035 req=3'b111 held continuously from reset -> grants in order 0,1,2,0 with done each, one IDLE gap between.
REQ-036 Model never drops ready, TIMEOUT_CYCLES=100 -> err[winner] pulse at cycle 99 after launch, no done, next requester granted.
REQ-037 ctrl_ready=0 at grant time for 5 cycles -> remains in LAUNCH, ctrl_start=0 until ready=1, then normal completion.
REQ-038 reset asserted while in WAIT_DONE -> next edge all outputs zero, rr_ptr=0, no done/err pulse; subsequent req[2] served normally.
